// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, with divide-by-zero/overflow fast paths, back-pressure and kill.
module rv_muldiv_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned TAGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [TAGW-1:0] i_tag,
  input  logic            i_kill,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic [TAGW-1:0] o_tag
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [TAGW-1:0]   tag_q, tag_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic              neg_q, neg_d;
  logic              rneg_q, rneg_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic            accept, is_div, rs1_signed, rs2_signed, rs1_neg, rs2_neg;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] mag1, mag2, fast_result;

  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] mul_next, div_next, iter, prod_s;
  logic [XLEN-1:0]   quot, rem, fin_result;

  assign o_ready  = (state_q == StIdle) && reset;
  assign o_valid  = (state_q == StDone);
  assign o_result = result_q;
  assign o_tag    = tag_q;

  assign accept = i_valid && o_ready && !i_kill;

  // Operand signedness: divides by funct3[0], multiplies by the MULHSU/MULHU encodings.
  always_comb begin
    is_div      = i_funct3[2];
    rs1_signed  = is_div ? !i_funct3[0] : (i_funct3[1:0] != 2'b11);
    rs2_signed  = is_div ? !i_funct3[0] : !i_funct3[1];
    rs1_neg     = rs1_signed && i_rs1[XLEN-1];
    rs2_neg     = rs2_signed && i_rs2[XLEN-1];
    mag1        = rs1_neg ? -i_rs1 : i_rs1;
    mag2        = rs2_neg ? -i_rs2 : i_rs2;
    div_zero    = is_div && (i_rs2 == '0);
    div_ovf     = is_div && !i_funct3[0] && (i_rs1 == MinNeg) && (i_rs2 == '1);
    fast_result = div_zero ? (i_funct3[1] ? i_rs1 : '1) : (i_funct3[1] ? '0 : i_rs1);
  end

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opb_q : '0)};
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    div_ge    = (div_shift >= {1'b0, opb_q});
    div_next  = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    iter      = funct3_q[2] ? div_next : mul_next;
    prod_s    = neg_q ? -iter : iter;
    quot      = iter[XLEN-1:0];
    rem       = iter[2*XLEN-1:XLEN];
    if (!funct3_q[2]) begin
      fin_result = (funct3_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end else if (funct3_q[1]) begin
      fin_result = rneg_q ? -rem : rem;
    end else begin
      fin_result = neg_q ? -quot : quot;
    end
  end

  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    tag_d    = tag_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          funct3_d = i_funct3;
          tag_d    = i_tag;
          neg_d    = rs1_neg ^ rs2_neg;
          rneg_d   = rs1_neg;
          opb_d    = is_div ? mag2 : mag1;
          acc_d    = {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
          cnt_d    = CntW'(XLEN - 1);
          if (div_zero || div_ovf) begin
            result_d = fast_result;
            state_d  = StDone;
          end else begin
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (i_kill) begin
          state_d = StIdle;
        end else begin
          acc_d = iter;
          if (cnt_q == '0) begin
            result_d = fin_result;
            state_d  = StDone;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      StDone: begin
        if (i_kill || i_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      funct3_q <= '0;
      tag_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      tag_q    <= tag_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

endmodule

// File: doc/rv_muldiv_unit.md
Name: rv_muldiv_unit

Overview:
- Parametrised iterative multiply/divide execution unit implementing the RV32M/RV64M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits beside the integer ALU in the CPU execute stage. The CPU FSM issues an operation through a valid/ready handshake and stalls until the result handshake completes.
- Computes one bit per cycle: shift-add for multiply, restoring division for divide.
- Provides divide-by-zero and signed-overflow fast paths, result back-pressure and an abort (kill) input.

Parameters:
- XLEN, 32, operand/result width in bits; legal values 8–64.
- TAGW, 5, width of the destination-register tag carried through the unit.

Ports:
- clk  in  1  clock; everything is sampled on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_valid  in  1  operation request.
- o_ready  out  1  unit can accept a request.
- i_funct3  in  3  RV M-extension funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_rs1  in  XLEN  operand 1 (multiplicand / dividend).
- i_rs2  in  XLEN  operand 2 (multiplier / divisor).
- i_tag  in  TAGW  destination-register tag.
- i_kill  in  1  abort the operation in flight.
- o_valid  out  1  result available.
- i_ready  in  1  consumer accepts the result.
- o_result  out  XLEN  result.
- o_tag  out  TAGW  tag of the result.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; o_valid=0, o_result=0, o_tag=0.
  - o_ready is forced to 0 while reset is low.
  - All internal accumulators and counters are cleared.
- States: IDLE, BUSY, DONE.
- o_ready = (state==IDLE) && reset. It is combinational and does not depend on i_valid.
- Accept:
  - Occurs on an edge where i_valid && o_ready && !i_kill.
  - Latches funct3, tag, the operand magnitudes, and the result-sign flags.
  - Signedness: MUL/MULH/DIV/REM treat both operands as signed; MULHSU treats rs1 signed, rs2 unsigned; MULHU/DIVU/REMU treat both unsigned.
- Normal path:
  - IDLE→BUSY on accept; the iteration counter loads XLEN-1.
  - BUSY executes one iteration per cycle for exactly XLEN cycles, then →DONE.
  - Sign fixup is applied on the final BUSY edge.
  - If the accept edge ends cycle 0, o_valid first rises in cycle XLEN+1.
- Multiply:
  - Computes the full 2·XLEN-bit magnitude product, negated if the operand signs differ (signed operands only).
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide:
  - Restoring division on magnitudes.
  - The quotient is negated if the operand signs differ (DIV only).
  - The remainder takes the sign of the dividend (REM only).
- Fast paths (IDLE→DONE directly; o_valid in cycle 1):
  - Divisor == 0: DIV/DIVU return all-ones; REM/REMU return rs1.
  - DIV/REM with rs1 == most-negative and rs2 == -1: DIV returns rs1; REM returns 0.
- DONE:
  - o_valid=1. o_result and o_tag are registered and held stable until the edge with i_ready=1.
  - On that edge →IDLE; o_valid=0 next cycle.
  - No new request is accepted in the same cycle as result acceptance (o_ready=0 in DONE).
- Kill:
  - i_kill=1 in BUSY or DONE → IDLE on the next edge; o_valid=0; no result is delivered.
  - i_kill has priority over i_ready and over accept.
  - i_kill in IDLE blocks acceptance even when i_valid=1.
- x0 tag: the unit does not special-case tag 0; the register-file writeback discards it.
- i_funct3 and the operands are don't-care when not accepting; changes while BUSY have no effect.
- Reset asserted mid-operation aborts immediately; outputs return to their reset values asynchronously.

Test Plan:
1. MUL, rs1=7, rs2=0xFFFFFFFD, tag=5 (accept in cycle 0) -> o_valid=1 first in cycle 33, o_result=0xFFFFFFEB, o_tag=5; o_ready=0 in cycles 1–33.
2. MULH 0x80000000×0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
3. Signed and unsigned divide:
   - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
   - DIVU 100/7 -> 14; REMU 100/7 -> 2.
   - All four: o_valid in cycle 33.
4. Fast paths:
   - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
   - All: o_valid in cycle 1.
5. Back-pressure: hold i_ready=0 for 10 cycles after o_valid -> o_valid, o_result and o_tag stable; o_ready=0. Raise i_ready -> o_valid=0 and o_ready=1 next cycle. Issue a new DIVU 9/3 -> 3.
6. Abort and reset:
   - Assert i_kill in cycle 10 of a MUL -> state IDLE next cycle, o_ready=1, o_valid never rises.
   - A following MULHU 2×3 -> 0.
   - Drop reset mid-BUSY -> o_valid, o_result and o_tag all 0 immediately, o_ready=0 until reset is released.
